// File: rtl/aes_pkg.sv
// Shared constants, FSM state type and AES round primitives (S-box, ShiftRows,
// MixColumns, key schedule) used by the iterative AES-128 round engine.
package aes_pkg;

  localparam int NUM_ROUNDS = 10;
  localparam int BLOCK_W    = 128;

  // Bit n set means UNROLL = n is legal (n divides NUM_ROUNDS: 1, 2, 5, 10).
  localparam logic [NUM_ROUNDS:0] UNROLL_LEGAL = 11'b100_0010_0110;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } aes_fsm_e;

  localparam logic [7:0] SBOX [256] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  function automatic bit unroll_ok(input int u);
    if (u < 1 || u > NUM_ROUNDS) return 1'b0;
    return UNROLL_LEGAL[u[3:0]];
  endfunction

  // Byte k of the state is column k/4, row k%4; byte 0 sits in the MSBs.
  function automatic logic [7:0] get_byte(input logic [BLOCK_W-1:0] s, input int k);
    return s[BLOCK_W-1-8*k -: 8];
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] rcon(input logic [3:0] rc);
    case (rc)
      4'd1:    return 8'h01;
      4'd2:    return 8'h02;
      4'd3:    return 8'h04;
      4'd4:    return 8'h08;
      4'd5:    return 8'h10;
      4'd6:    return 8'h20;
      4'd7:    return 8'h40;
      4'd8:    return 8'h80;
      4'd9:    return 8'h1b;
      4'd10:   return 8'h36;
      default: return 8'h00;
    endcase
  endfunction

  function automatic logic [BLOCK_W-1:0] sub_bytes(input logic [BLOCK_W-1:0] s);
    logic [BLOCK_W-1:0] r;
    for (int k = 0; k < 16; k++) r[8*k +: 8] = SBOX[s[8*k +: 8]];
    return r;
  endfunction

  function automatic logic [BLOCK_W-1:0] shift_rows(input logic [BLOCK_W-1:0] s);
    logic [BLOCK_W-1:0] r;
    for (int c = 0; c < 4; c++)
      for (int w = 0; w < 4; w++)
        r[BLOCK_W-1-8*(4*c+w) -: 8] = get_byte(s, 4*((c+w)%4)+w);
    return r;
  endfunction

  function automatic logic [BLOCK_W-1:0] mix_columns(input logic [BLOCK_W-1:0] s);
    logic [BLOCK_W-1:0] r;
    logic [7:0] a0, a1, a2, a3;
    for (int c = 0; c < 4; c++) begin
      a0 = get_byte(s, 4*c);
      a1 = get_byte(s, 4*c+1);
      a2 = get_byte(s, 4*c+2);
      a3 = get_byte(s, 4*c+3);
      r[BLOCK_W-1-32*c -: 32] = {
        xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
        a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
        a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
        xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
    end
    return r;
  endfunction

  function automatic logic [BLOCK_W-1:0] key_generation(input logic [BLOCK_W-1:0] k,
                                                        input logic [3:0] rc);
    logic [31:0] w0, w1, w2, w3, t;
    w0 = k[127:96];
    w1 = k[95:64];
    w2 = k[63:32];
    w3 = k[31:0];
    t  = {SBOX[w3[23:16]] ^ rcon(rc), SBOX[w3[15:8]], SBOX[w3[7:0]], SBOX[w3[31:24]]};
    w0 = w0 ^ t;
    w1 = w1 ^ w0;
    w2 = w2 ^ w1;
    w3 = w3 ^ w2;
    return {w0, w1, w2, w3};
  endfunction

endpackage

// File: rtl/aes_round_stage.sv
// One combinational AES-128 encryption round: next round key from (key, rc),
// then SubBytes, ShiftRows, MixColumns (skipped on the last round), AddRoundKey.
module aes_round_stage
  import aes_pkg::*;
(
  input  logic [BLOCK_W-1:0] state_i,
  input  logic [BLOCK_W-1:0] key_i,
  input  logic [3:0]         rc_i,
  input  logic               last_i,
  output logic [BLOCK_W-1:0] state_o,
  output logic [BLOCK_W-1:0] key_o
);

  logic [BLOCK_W-1:0] shifted;

  assign key_o   = key_generation(key_i, rc_i);
  assign shifted = shift_rows(sub_bytes(state_i));
  assign state_o = (last_i ? shifted : mix_columns(shifted)) ^ key_o;

endmodule

// File: rtl/aes_round_engine.sv
// Iterative AES-128 encryptor computing UNROLL rounds per clock with a
// valid/ready handshake on both sides. Optional macro AES_KEY_REUSE_EN adds
// in_key_load so a block can reuse the key stored from an earlier accept.
module aes_round_engine
  import aes_pkg::*;
#(
  parameter int UNROLL = 1
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [BLOCK_W-1:0] in_data,
  input  logic [BLOCK_W-1:0] in_key,
`ifdef AES_KEY_REUSE_EN
  input  logic               in_key_load,
`endif
  output logic               out_valid,
  input  logic               out_ready,
  output logic [BLOCK_W-1:0] out_data,
  output logic               busy
);

  if (!unroll_ok(UNROLL)) begin : g_bad_unroll
    $error("aes_round_engine: UNROLL must be 1, 2, 5 or 10");
  end

  aes_fsm_e           fsm_q, fsm_d;
  logic [3:0]         rc_q, rc_d;
  logic [BLOCK_W-1:0] state_q, state_d;
  logic [BLOCK_W-1:0] key_q, key_d;
  logic [BLOCK_W-1:0] out_q, out_d;
  logic [BLOCK_W-1:0] key_sel;
  logic [4:0]         rc_end;

  logic [BLOCK_W-1:0] st_chain  [UNROLL+1];
  logic [BLOCK_W-1:0] key_chain [UNROLL+1];

  assign st_chain[0]  = state_q;
  assign key_chain[0] = key_q;

  for (genvar g = 0; g < UNROLL; g++) begin : g_round
    logic [3:0] rc_g;
    assign rc_g = rc_q + 4'(g);
    aes_round_stage u_stage (
      .state_i (st_chain[g]),
      .key_i   (key_chain[g]),
      .rc_i    (rc_g),
      .last_i  (rc_g == 4'(NUM_ROUNDS)),
      .state_o (st_chain[g+1]),
      .key_o   (key_chain[g+1])
    );
  end

  // Round number handled by the last stage of the chain this clock.
  assign rc_end = {1'b0, rc_q} + 5'(UNROLL - 1);

`ifdef AES_KEY_REUSE_EN
  logic [BLOCK_W-1:0] key_store_q, key_store_d;

  assign key_sel = in_key_load ? in_key : key_store_q;

  always_comb begin
    key_store_d = key_store_q;
    if (fsm_q == IDLE && in_valid && in_key_load) key_store_d = in_key;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) key_store_q <= '0;
    else       key_store_q <= key_store_d;
  end
`else
  assign key_sel = in_key;
`endif

  always_comb begin
    fsm_d   = fsm_q;
    rc_d    = rc_q;
    state_d = state_q;
    key_d   = key_q;
    out_d   = out_q;
    case (fsm_q)
      IDLE: begin
        if (in_valid) begin
          state_d = in_data ^ key_sel;
          key_d   = key_sel;
          rc_d    = 4'd1;
          fsm_d   = RUN;
        end
      end
      RUN: begin
        state_d = st_chain[UNROLL];
        key_d   = key_chain[UNROLL];
        if (rc_end == 5'(NUM_ROUNDS)) begin
          out_d = st_chain[UNROLL];
          rc_d  = 4'(NUM_ROUNDS);
          fsm_d = DONE;
        end else begin
          rc_d = rc_q + 4'(UNROLL);
        end
      end
      DONE: begin
        if (out_ready) fsm_d = IDLE;
      end
      default: fsm_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      fsm_q   <= IDLE;
      rc_q    <= '0;
      state_q <= '0;
      key_q   <= '0;
      out_q   <= '0;
    end else begin
      fsm_q   <= fsm_d;
      rc_q    <= rc_d;
      state_q <= state_d;
      key_q   <= key_d;
      out_q   <= out_d;
    end
  end

  assign in_ready  = (fsm_q == IDLE);
  assign out_valid = (fsm_q == DONE);
  assign busy      = (fsm_q != IDLE);
  assign out_data  = out_q;

endmodule
